retirement_rmt_multilane: RTL and testbench
===========================================

// Module: retirement_rmt_multilane
// PURPOSE
//  Next-generation retirement register map table (committed logical->physical map) for the rename stage.
//  Generalised over commit/read/recovery lane counts.
//  Adds a multi-cycle power-on init sweep and a handshaked recovery stream that copies the committed
//  map back into the speculative RMT after a flush.
// PARAMETERS
//  ENTRY_NUM         32  logical registers mapped; multiple of INIT_WIDTH and RECOVER_WIDTH
//  LREG_BITS         $clog2(ENTRY_NUM)  logical register index width (derived)
//  PREG_BITS         7   physical register index width
//  COMMIT_WIDTH      2   commit write lanes per cycle
//  READ_WIDTH        2   asynchronous read lanes
//  INIT_WIDTH        2   entries initialised per cycle
//  RECOVER_WIDTH     4   entries streamed per recovery beat
//  FREE_LIST_OFFSET  96  init map value base: entry i resets to i+FREE_LIST_OFFSET (must fit PREG_BITS)
// PORTS
//  clk            in   1                        clock
//  rst            in   1                        reset, asynchronous, active-high
//  commit_ready   out  1                        map accepts commits (RUN state)
//  commit_we      in   COMMIT_WIDTH             per-lane commit write enable
//  commit_lreg    in   COMMIT_WIDTH*LREG_BITS   logical dest per lane; lane 0 oldest
//  commit_preg    in   COMMIT_WIDTH*PREG_BITS   committed physical reg per lane
//  read_lreg      in   READ_WIDTH*LREG_BITS     read addresses
//  read_preg      out  READ_WIDTH*PREG_BITS     read data, combinational
//  recover_req    in   1                        one-cycle pulse: start recovery stream
//  recover_valid  out  1                        beat valid
//  recover_ready  in   1                        consumer accepts beat
//  recover_lreg   out  LREG_BITS                first logical index of beat (multiple of RECOVER_WIDTH)
//  recover_preg   out  RECOVER_WIDTH*PREG_BITS  map[lreg+k] on slice k
//  recover_last   out  1                        final beat of stream
//  init_done      out  1                        init sweep finished; held high until reset
//  err_drop       out  1                        sticky: commit_we seen while commit_ready=0
// BEHAVIOUR
//  - States: INIT -> RUN <-> RECOVER.
//  - rst asserted: state=INIT, counters=0, pending=0. All outputs 0 except read_preg (array contents, undefined).
//  - INIT: each cycle writes map[c+k] = c+k+FREE_LIST_OFFSET for k<INIT_WIDTH, then c += INIT_WIDTH.
//    Takes ENTRY_NUM/INIT_WIDTH cycles; on the last write -> RUN, init_done=1 from the next cycle.
//  - RUN: commit_ready=1. For each lane with commit_we, map[lreg] <= preg at posedge.
//    Same-lreg collision across lanes: highest-numbered (youngest) lane wins; older lanes are suppressed.
//  - commit_we while commit_ready=0: write dropped, err_drop set (cleared only by rst).
//  - read_preg[i] = map[read_lreg[i]], combinational; pre-write value of the current cycle.
//  - recover_req in RUN: next cycle -> RECOVER, beat counter b=0.
//    A commit in that same cycle is applied first and is visible in the stream.
//  - recover_req in INIT: latched as pending; RECOVER entered the cycle after init completes.
//  - recover_req in RECOVER: ignored; no restart.
//  - RECOVER: recover_valid=1, recover_lreg=b*RECOVER_WIDTH, recover_preg = map slice.
//    The beat is held stable while recover_ready=0. On valid&&ready, b++.
//    recover_last=1 when b = ENTRY_NUM/RECOVER_WIDTH-1; acceptance of that beat -> RUN next cycle.
//  - Commits are blocked in RECOVER, so the streamed map is a consistent snapshot.
//  - Counter wrap: b and c never exceed their last value; no wrap to 0 inside a state.
//  - rst mid-INIT or mid-RECOVER: aborts immediately (async); the sweep restarts from entry 0.
// CONFIGURATION
//  - RRMT_READ_BYPASS_EN defined: read_preg[i] returns commit_preg of the youngest commit lane with
//    commit_we && lreg match in the same cycle (when commit_ready=1), else the array value.
//  - Undefined: no bypass; reads always return the pre-write array value.
// TESTING
//  - Reset/init: pulse rst, wait 16 cycles -> init_done=1 on cycle 17; read_lreg=5 -> 101, lreg=31 -> 127.
//  - Collision: lanes 0,1 both write lreg 3 (preg 10, 20) -> next cycle read lreg 3 = 20. Bypass on: 20 same cycle.
//  - Recovery backpressure: write lreg 4=7, recover_req; hold ready=0 for 3 cycles, then 1 ->
//    8 beats, lreg 0,4,..,28; beat1 slice0=7, stable while stalled; last=1 only on beat 7; RUN after.
//  - Early recover: recover_req in INIT cycle 3 -> first recover_valid the cycle after init ends; stream intact.
//  - Drop: commit_we=01 during RECOVER -> map unchanged, err_drop=1 and stays 1 after RUN.
//  - Mid-op reset: rst during beat 5 -> valid=0 immediately; init restarts and the map returns to init values.

Source files
------------

// File: rtl/retirement_rmt_multilane.sv
// retirement_rmt_multilane: committed logical->physical register map for the rename stage.
// Runs a multi-cycle init sweep after reset. In RUN it accepts per-lane commits, and it can stream
// the whole map out in handshaked beats to restore the speculative RMT after a flush.
// Optional feature macro: RRMT_READ_BYPASS_EN. When defined, reads forward same-cycle commit data.
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   commit_ready    high in RUN; commits are accepted only then
//   commit_we/lreg/preg  per-lane commit writes; a higher lane is younger
//   read_lreg/read_preg  combinational read lanes
//   recover_req     one-cycle pulse that starts the recovery stream
//   recover_valid/ready/lreg/preg/last  recovery beat handshake and payload
//   init_done       sticky flag, set once the init sweep has finished
//   err_drop        sticky flag, set when a commit arrives while commit_ready is low
module retirement_rmt_multilane #(
    parameter int unsigned ENTRY_NUM        = 32,
    parameter int unsigned LREG_BITS        = $clog2(ENTRY_NUM),
    parameter int unsigned PREG_BITS        = 7,
    parameter int unsigned COMMIT_WIDTH     = 2,
    parameter int unsigned READ_WIDTH       = 2,
    parameter int unsigned INIT_WIDTH       = 2,
    parameter int unsigned RECOVER_WIDTH    = 4,
    parameter int unsigned FREE_LIST_OFFSET = 96
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              commit_ready,
    input  logic [COMMIT_WIDTH-1:0]           commit_we,
    input  logic [COMMIT_WIDTH*LREG_BITS-1:0] commit_lreg,
    input  logic [COMMIT_WIDTH*PREG_BITS-1:0] commit_preg,
    input  logic [READ_WIDTH*LREG_BITS-1:0]   read_lreg,
    output logic [READ_WIDTH*PREG_BITS-1:0]   read_preg,
    input  logic                              recover_req,
    output logic                              recover_valid,
    input  logic                              recover_ready,
    output logic [LREG_BITS-1:0]              recover_lreg,
    output logic [RECOVER_WIDTH*PREG_BITS-1:0] recover_preg,
    output logic                              recover_last,
    output logic                              init_done,
    output logic                              err_drop
);

    localparam int unsigned BEAT_NUM  = ENTRY_NUM / RECOVER_WIDTH;
    localparam int unsigned BEAT_BITS = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;
    localparam logic [BEAT_BITS-1:0] BEAT_LAST     = BEAT_BITS'(BEAT_NUM - 1);
    localparam logic [LREG_BITS-1:0] INIT_LAST_IDX = LREG_BITS'(ENTRY_NUM - INIT_WIDTH);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_RUN     = 2'd1,
        S_RECOVER = 2'd2
    } stateE;

    stateE                state, stateNext;
    logic [LREG_BITS-1:0] initCnt, initCntNext;
    logic [BEAT_BITS-1:0] beatCnt, beatCntNext;
    logic                 pendingQ, pendingNext;
    logic                 initDoneQ, initDoneNext;
    logic                 errDropQ, errDropNext;
    logic                 commitReadyQ, recValidQ, recLastQ;
    logic                 initWe;
    logic [COMMIT_WIDTH-1:0] commitEn;
    logic [LREG_BITS-1:0] recLreg;

    logic [PREG_BITS-1:0] mapQ [ENTRY_NUM];

    // Commits only take effect while the map is accepting them.
    assign commitEn = commitReadyQ ? commit_we : '0;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_INIT;
            initCnt      <= '0;
            beatCnt      <= '0;
            pendingQ     <= 1'b0;
            initDoneQ    <= 1'b0;
            errDropQ     <= 1'b0;
            commitReadyQ <= 1'b0;
            recValidQ    <= 1'b0;
            recLastQ     <= 1'b0;
        end else begin
            state        <= stateNext;
            initCnt      <= initCntNext;
            beatCnt      <= beatCntNext;
            pendingQ     <= pendingNext;
            initDoneQ    <= initDoneNext;
            errDropQ     <= errDropNext;
            commitReadyQ <= (stateNext == S_RUN);
            recValidQ    <= (stateNext == S_RECOVER);
            recLastQ     <= (stateNext == S_RECOVER) && (beatCntNext == BEAT_LAST);
        end
    end

    // Next-state logic for the init sweep, run phase and recovery stream.
    always_comb begin
        stateNext    = state;
        initCntNext  = initCnt;
        beatCntNext  = beatCnt;
        pendingNext  = pendingQ;
        initDoneNext = initDoneQ;
        errDropNext  = errDropQ | ((|commit_we) & ~commitReadyQ);
        initWe       = 1'b0;
        case (state)
            S_INIT: begin
                initWe = 1'b1;
                if (recover_req) pendingNext = 1'b1;
                if (initCnt == INIT_LAST_IDX) begin
                    // A recovery requested during init starts right after the sweep.
                    initDoneNext = 1'b1;
                    pendingNext  = 1'b0;
                    beatCntNext  = '0;
                    stateNext    = (pendingQ || recover_req) ? S_RECOVER : S_RUN;
                end else begin
                    initCntNext = initCnt + LREG_BITS'(INIT_WIDTH);
                end
            end
            S_RUN: begin
                if (recover_req) begin
                    beatCntNext = '0;
                    stateNext   = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (recover_ready) begin
                    if (beatCnt == BEAT_LAST) stateNext = S_RUN;
                    else                      beatCntNext = beatCnt + BEAT_BITS'(1);
                end
            end
            default: stateNext = S_INIT;
        endcase
    end

    // Map array; later lanes are assigned last, so the youngest lane wins a collision.
    always_ff @(posedge clk) begin
        if (initWe) begin
            for (int k = 0; k < int'(INIT_WIDTH); k++) begin
                mapQ[initCnt + LREG_BITS'(k)] <=
                    PREG_BITS'(32'(initCnt) + 32'(k) + FREE_LIST_OFFSET);
            end
        end else begin
            for (int l = 0; l < int'(COMMIT_WIDTH); l++) begin
                if (commitEn[l]) begin
                    mapQ[commit_lreg[l*LREG_BITS +: LREG_BITS]] <=
                        commit_preg[l*PREG_BITS +: PREG_BITS];
                end
            end
        end
    end

    // Asynchronous read lanes.
    always_comb begin
        read_preg = '0;
        for (int i = 0; i < int'(READ_WIDTH); i++) begin
            read_preg[i*PREG_BITS +: PREG_BITS] = mapQ[read_lreg[i*LREG_BITS +: LREG_BITS]];
`ifdef RRMT_READ_BYPASS_EN
            // Youngest matching commit lane overrides the array value.
            for (int l = 0; l < int'(COMMIT_WIDTH); l++) begin
                if (commitEn[l] &&
                    (commit_lreg[l*LREG_BITS +: LREG_BITS] == read_lreg[i*LREG_BITS +: LREG_BITS])) begin
                    read_preg[i*PREG_BITS +: PREG_BITS] = commit_preg[l*PREG_BITS +: PREG_BITS];
                end
            end
`endif
        end
    end

    // Recovery beat payload; forced to zero outside RECOVER so reset outputs are defined.
    assign recLreg = recValidQ ? LREG_BITS'(32'(beatCnt) * RECOVER_WIDTH) : '0;

    always_comb begin
        recover_preg = '0;
        for (int k = 0; k < int'(RECOVER_WIDTH); k++) begin
            if (recValidQ) begin
                recover_preg[k*PREG_BITS +: PREG_BITS] = mapQ[recLreg + LREG_BITS'(k)];
            end
        end
    end

    assign commit_ready  = commitReadyQ;
    assign recover_valid = recValidQ;
    assign recover_lreg  = recLreg;
    assign recover_last  = recLastQ;
    assign init_done     = initDoneQ;
    assign err_drop      = errDropQ;

endmodule

// File: tb/tb_retirement_rmt_multilane.sv
// Testbench for retirement_rmt_multilane: directed vectors. Recovery beats go through a scoreboard queue
// that is checked by an independent monitor. Other checks are direct comparisons.
module tb_retirement_rmt_multilane;

    localparam int unsigned EN = 32;
    localparam int unsigned LB = 5;
    localparam int unsigned PB = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           commit_ready;
    logic [1:0]     commit_we = '0;
    logic [9:0]     commit_lreg = '0;
    logic [13:0]    commit_preg = '0;
    logic [9:0]     read_lreg = '0;
    logic [13:0]    read_preg;
    logic           recover_req = 1'b0;
    logic           recover_valid;
    logic           recover_ready = 1'b0;
    logic [4:0]     recover_lreg;
    logic [27:0]    recover_preg;
    logic           recover_last;
    logic           init_done;
    logic           err_drop;

    typedef struct packed {
        logic [4:0]  lreg;
        logic [27:0] preg;
        logic        last;
    } beatT;

    beatT sbQ[$];
    int   nCompared   = 0;
    int   nMismatched = 0;
    int   expMap[EN];

    retirement_rmt_multilane dut (
        .clk          (clk),
        .rst          (rst),
        .commit_ready (commit_ready),
        .commit_we    (commit_we),
        .commit_lreg  (commit_lreg),
        .commit_preg  (commit_preg),
        .read_lreg    (read_lreg),
        .read_preg    (read_preg),
        .recover_req  (recover_req),
        .recover_valid(recover_valid),
        .recover_ready(recover_ready),
        .recover_lreg (recover_lreg),
        .recover_preg (recover_preg),
        .recover_last (recover_last),
        .init_done    (init_done),
        .err_drop     (err_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic modelInit();
        for (int i = 0; i < int'(EN); i++) expMap[i] = i + 96;
    endtask

    // Snapshot of the model map as the eight expected recovery beats.
    task automatic pushStream();
        beatT b;
        for (int n = 0; n < 8; n++) begin
            b.lreg = 5'(n * 4);
            for (int k = 0; k < 4; k++) b.preg[k*PB +: PB] = 7'(expMap[n*4 + k]);
            b.last = (n == 7);
            sbQ.push_back(b);
        end
    endtask

    // Wait (bounded) for the stream to finish and the block to leave RECOVER.
    task automatic drain();
        int cyc = 0;
        while ((sbQ.size() != 0 || recover_valid) && cyc < 60) begin
            tick();
            cyc++;
        end
        check("stream_drained", 32'(sbQ.size()), 0);
        check("stream_valid_low", 32'(recover_valid), 0);
    endtask

    // Monitor: every accepted beat is compared with the scoreboard head.
    always @(negedge clk) begin
        beatT act;
        beatT exp;
        if (!rst && recover_valid && recover_ready) begin
            act = {recover_lreg, recover_preg, recover_last};
            nCompared++;
            if (sbQ.size() == 0) begin
                nMismatched++;
                $display("FAIL beat_unexpected: got lreg=%0d preg=%h last=%0d with empty queue",
                         act.lreg, act.preg, act.last);
            end else begin
                exp = sbQ.pop_front();
                if (act !== exp) begin
                    nMismatched++;
                    $display("FAIL beat: got lreg=%0d preg=%h last=%0d expected lreg=%0d preg=%h last=%0d",
                             act.lreg, act.preg, act.last, exp.lreg, exp.preg, exp.last);
                end
            end
        end
    end

    initial begin
        // Reset state.
        repeat (2) tick();
        check("rst_commit_ready", 32'(commit_ready), 0);
        check("rst_recover_valid", 32'(recover_valid), 0);
        check("rst_recover_last", 32'(recover_last), 0);
        check("rst_recover_lreg", 32'(recover_lreg), 0);
        check("rst_recover_preg", 32'(recover_preg), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_err_drop", 32'(err_drop), 0);

        // Init sweep: 16 cycles.
        rst = 1'b0;
        modelInit();
        repeat (15) tick();
        check("init_done_c16", 32'(init_done), 0);
        tick();
        check("init_done_c17", 32'(init_done), 1);
        check("run_commit_ready", 32'(commit_ready), 1);
        read_lreg = {5'd31, 5'd5};
        #1;
        check("read_init_5", 32'(read_preg[6:0]), 101);
        check("read_init_31", 32'(read_preg[13:7]), 127);

        // Same-lreg collision: youngest lane wins.
        commit_we   = 2'b11;
        commit_lreg = {5'd3, 5'd3};
        commit_preg = {7'd20, 7'd10};
        read_lreg   = {5'd3, 5'd3};
        #1;
`ifdef RRMT_READ_BYPASS_EN
        check("collide_same_cycle", 32'(read_preg[6:0]), 20);
`else
        check("collide_same_cycle", 32'(read_preg[6:0]), 99);
`endif
        tick();
        commit_we = 2'b00;
        expMap[3] = 20;
        #1;
        check("collide_next_cycle", 32'(read_preg[6:0]), 20);

        // Commit and recover_req in the same cycle; commits appear in the stream.
        commit_we     = 2'b11;
        commit_lreg   = {5'd9, 5'd4};
        commit_preg   = {7'd55, 7'd7};
        recover_req   = 1'b1;
        recover_ready = 1'b1;
        expMap[4] = 7;
        expMap[9] = 55;
        pushStream();
        tick();
        commit_we   = 2'b00;
        recover_req = 1'b0;
        check("recover_commit_ready", 32'(commit_ready), 0);
        check("recover_valid_on", 32'(recover_valid), 1);
        tick();
        // Stall on beat 1; a dropped commit and an ignored recover_req arrive here.
        recover_ready = 1'b0;
        commit_we     = 2'b01;
        commit_lreg   = {5'd0, 5'd4};
        commit_preg   = {7'd0, 7'd99};
        recover_req   = 1'b1;
        tick();
        commit_we   = 2'b00;
        recover_req = 1'b0;
        check("err_drop_set", 32'(err_drop), 1);
        for (int s = 0; s < 2; s++) begin
            check("stall_lreg", 32'(recover_lreg), 4);
            check("stall_slice0", 32'(recover_preg[6:0]), 7);
            tick();
        end
        check("stall_lreg", 32'(recover_lreg), 4);
        check("stall_slice0", 32'(recover_preg[6:0]), 7);
        recover_ready = 1'b1;
        drain();
        check("after_recover_run", 32'(commit_ready), 1);
        check("err_drop_sticky", 32'(err_drop), 1);
        read_lreg = {5'd9, 5'd4};
        #1;
        check("drop_no_write", 32'(read_preg[6:0]), 7);
        check("read_lreg9", 32'(read_preg[13:7]), 55);

        // Reset in the middle of the stream.
        recover_req = 1'b1;
        pushStream();
        tick();
        recover_req = 1'b0;
        repeat (5) tick();
        check("beat5_lreg", 32'(recover_lreg), 20);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(recover_valid), 0);
        check("midrst_commit_ready", 32'(commit_ready), 0);
        check("midrst_init_done", 32'(init_done), 0);
        check("midrst_err_drop", 32'(err_drop), 0);
        sbQ.delete();
        recover_ready = 1'b0;
        tick();
        rst = 1'b0;
        modelInit();

        // Recovery requested during init cycle 3.
        repeat (2) tick();
        recover_req = 1'b1;
        tick();
        recover_req = 1'b0;
        pushStream();
        repeat (12) tick();
        check("early_valid_c16", 32'(recover_valid), 0);
        check("early_init_done_c16", 32'(init_done), 0);
        tick();
        check("early_init_done", 32'(init_done), 1);
        check("early_valid_first", 32'(recover_valid), 1);
        check("early_commit_ready", 32'(commit_ready), 0);
        read_lreg = {5'd3, 5'd4};
        #1;
        check("reinit_lreg4", 32'(read_preg[6:0]), 100);
        check("reinit_lreg3", 32'(read_preg[13:7]), 99);
        recover_ready = 1'b1;
        drain();
        check("early_run", 32'(commit_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
